// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder stage, LSB first.
// Result and carry are published together once the last bit is processed.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;

   logic ha1_s, ha1_c, ha2_c;
   logic fa_s, fa_c;

   // Full adder from two half adders; operands are shifted so bit 0 is current
   assign ha1_s = a_q[0] ^ b_q[0];
   assign ha1_c = a_q[0] & b_q[0];
   assign fa_s  = ha1_s ^ c_q;
   assign ha2_c = ha1_s & c_q;
   assign fa_c  = ha1_c | ha2_c;

   // Next-state: capture operands, step one bit per cycle, publish at the end
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               c_d     = sub ? 1'b1 : cin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            c_d = fa_c;
            res_d = res_q >> 1;
            res_d[WIDTH-1] = fa_s;
            if (cnt_q == LAST) begin
               sum_d   = res_d;
               carry_d = fa_c;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         res_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign sum   = sum_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
// Expected results are hand-computed constants or a tiny arithmetic model.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start8, sub8, cin8;
   logic [7:0] a8, b8;
   logic       busy8, done8, carry8;
   logic [7:0] sum8;

   logic       start1, sub1, cin1;
   logic [0:0] a1, b1;
   logic       busy1, done1, carry1;
   logic [0:0] sum1;

   int n_chk = 0;
   int n_fail = 0;
   int ndone;
   logic [7:0] prev_sum = 8'h00;
   logic       prev_carry = 1'b0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8),
      .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
      .sum(sum8), .carry(carry8)
   );

   serial_adder #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1),
      .a(a1), .b(b1), .cin(cin1), .busy(busy1), .done(done1),
      .sum(sum1), .carry(carry1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation; optionally pokes start with other operands mid-run
   task automatic op8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic [7:0] es, input logic ec,
                      input bit poke);
      @(negedge clk);
      start8 = 1'b1; sub8 = s; a8 = av; b8 = bv; cin8 = ci;
      @(posedge clk);
      #1;
      start8 = 1'b0; sub8 = ~s; a8 = ~av; b8 = av; cin8 = ~ci;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("busy8", busy8, 1);
         chk("done8_run", done8, 0);
         chk("hold8", {carry8, sum8}, {prev_carry, prev_sum});
         if (poke && i == 3) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
         end
         if (poke && i == 4) start8 = 1'b0;
      end
      @(negedge clk);
      chk("done8", done8, 1);
      chk("busy8_done", busy8, 0);
      chk("sum8", sum8, es);
      chk("carry8", carry8, ec);
      @(negedge clk);
      chk("done8_pulse", done8, 0);
      chk("busy8_idle", busy8, 0);
      prev_sum = es;
      prev_carry = ec;
   endtask

   task automatic op1(input logic s, input logic av, input logic bv,
                      input logic ci);
      logic [1:0] e;
      if (s) e = {(av >= bv), av ^ bv};
      else e = {1'b0, av} + {1'b0, bv} + {1'b0, ci};
      @(negedge clk);
      start1 = 1'b1; sub1 = s; a1 = av; b1 = bv; cin1 = ci;
      @(posedge clk);
      #1;
      start1 = 1'b0; sub1 = ~s; a1 = ~av; b1 = ~bv; cin1 = ~ci;
      @(negedge clk);
      chk("busy1", busy1, 1);
      @(negedge clk);
      chk("done1", done1, 1);
      chk("res1", {carry1, sum1}, e);
   endtask

   initial begin
      rst_n = 1'b0;
      start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      #12;
      chk("rst_out8", {busy8, done8, carry8, sum8}, 11'h000);
      chk("rst_out1", {busy1, done1, carry1, sum1}, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      op8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      op8(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      op8(1'b0, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0);
      op8(1'b1, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0);
      op8(1'b1, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
      op8(1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b1);
      op8(1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);

      // start held high: ops accepted at k and k+10
      @(negedge clk);
      start8 = 1'b1; sub8 = 1'b0; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
      @(posedge clk);
      ndone = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (done8) ndone++;
         if (j == 8 || j == 18) begin
            chk("b2b_done", done8, 1);
            chk("b2b_sum", {carry8, sum8}, 9'h030);
         end
         if (j == 9) chk("b2b_gap", busy8, 0);
         if (j == 10) chk("b2b_rerun", busy8, 1);
         if (j == 19) start8 = 1'b0;
      end
      chk("b2b_count", ndone, 2);
      @(negedge clk);
      chk("b2b_stop", busy8, 0);
      prev_sum = 8'h30;
      prev_carry = 1'b0;

      // reset pulse mid-run with counter at 4
      @(negedge clk);
      start8 = 1'b1; sub8 = 1'b0; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_busy", busy8, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async", {busy8, done8, carry8, sum8}, 11'h000);
      rst_n = 1'b1;
      prev_sum = 8'h00;
      prev_carry = 1'b0;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      chk("rst_nodone", ndone, 0);
      op8(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

      for (int v = 0; v < 16; v++) begin
         logic [3:0] t;
         t = v[3:0];
         op1(t[3], t[2], t[1], t[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
